alu_pipe_gen: RTL and testbench

Parametrised, handshaked successor to the fixed 16-bit two-stage ALU. It has a generic operand width and valid/ready flow control on both sides. Divide runs in an iterative multi-cycle unit that stalls intake, and operands are isolated to idle the multiplier and divider for power. It sits between the operand-fetch/issue logic and the writeback mux of the power-aware SoC datapath.

---
 rtl/alu_pipe_gen_pkg.sv | 39 +++
 rtl/alu_pipe_gen_if.sv | 31 +++
 rtl/alu_pipe_gen_div_iter.sv | 79 +++++++
 rtl/alu_pipe_gen.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe_gen.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_gen_pkg.sv
// Shared types for the handshaked ALU pipeline: op codes, divider FSM states
// and result-width helpers.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_ROR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_AND  = 4'd10,
    OP_OR   = 4'd11,
    OP_XOR  = 4'd12,
    OP_CMP  = 4'd13,
    OP_ILL0 = 4'd14,
    OP_ILL1 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 32;
  localparam int RES_MULT  = 2;

  // Result bus is wide enough for the full unsigned product.
  function automatic int res_width(input int w);
    return RES_MULT * w;
  endfunction

endpackage

// File: rtl/alu_pipe_gen_if.sv
// Operand/result bus of the ALU pipeline; master drives operations and
// out_ready, slave is the ALU.
interface alu_pipe_gen_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [WIDTH-1:0]                          a;
  logic [WIDTH-1:0]                          b;
  logic [SHW-1:0]                            shamt;
  logic [3:0]                                op;
  logic                                      cin;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [alu_pipe_pkg::res_width(WIDTH)-1:0] result;
  logic [WIDTH-1:0]                          remainder;
  logic                                      carry_out;
  logic                                      div_by_zero;
  logic                                      illegal_op;

  modport master (
    output in_valid, a, b, shamt, op, cin, out_ready,
    input  in_ready, out_valid, result, remainder, carry_out, div_by_zero, illegal_op
  );

  modport slave (
    input  in_valid, a, b, shamt, op, cin, out_ready,
    output in_ready, out_valid, result, remainder, carry_out, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_pipe_gen_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, result held in
// DONE until the consumer takes it. busy/done fully decode the FSM state.
module alu_div_iter
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             take,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH:0]   partial, diff;

  assign partial = {rem, quo[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        quo   <= dividend;
        rem   <= '0;
        dvs   <= divisor;
        count <= '0;
      end else if (state == ST_RUN) begin
        count <= count + 1'b1;
        // Keep the trial difference only when it did not go negative.
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= partial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (take) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_pipe_gen.sv
// Two-stage handshaked ALU: S1 holds the accepted operation, S2 holds the
// registered result. DIV with a nonzero divisor detours through alu_div_iter.
module alu_pipe_gen
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  alu_pipe_gen_if.slave bus
);
  localparam int RW = res_width(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and an offered output stays
  // stable until it is taken.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [SHW-1:0]   s1_shamt;
  op_e              s1_op;
  logic             s1_cin;

  logic             s2_load, in_fire, s1_is_div, s1_fire, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r;

  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign s1_is_div    = (s1_op == OP_DIV);
  assign div_start    = s1_valid && s1_is_div && (s1_b != '0) && !div_busy;
  assign s1_fire      = s1_valid && !(s1_is_div && (s1_b != '0)) && s2_load;
  assign bus.in_ready = !div_busy && (!s1_valid || (!s1_is_div && s2_load));
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_shamt <= '0;
      s1_op    <= OP_ADD;
      s1_cin   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_shamt <= bus.shamt;
      s1_op    <= op_e'(bus.op);
      s1_cin   <= bus.cin;
    end else if (s1_fire || div_start) begin
      s1_valid <= 1'b0;
    end
  end

  // One adder serves ADD/SUB/INC/DEC; DEC adds all-ones so carry means a != 0.
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_b = s1_b;
    add_c = s1_cin;
    case (s1_op)
      OP_SUB: add_b = ~s1_b;
      OP_INC: begin
        add_b = '0;
        add_c = 1'b1;
      end
      OP_DEC: begin
        add_b = '1;
        add_c = 1'b0;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, s1_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};

  // Multiplier sees zeros unless a MUL is in S1, so it does not toggle.
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [RW-1:0]    product;
  assign mul_a   = (s1_op == OP_MUL) ? s1_a : '0;
  assign mul_b   = (s1_op == OP_MUL) ? s1_b : '0;
  assign product = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

  logic [WIDTH-1:0] sra_v, ror_v;
  assign sra_v = $signed(s1_a) >>> s1_shamt;
  assign ror_v = WIDTH'({s1_a, s1_a} >> s1_shamt);

  logic [RW-1:0]    c_res;
  logic [WIDTH-1:0] c_rem;
  logic             c_carry, c_dbz, c_ill;

  always_comb begin
    c_res   = '0;
    c_rem   = '0;
    c_carry = 1'b0;
    c_dbz   = 1'b0;
    c_ill   = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        c_res   = RW'(add_sum[WIDTH-1:0]);
        c_carry = add_sum[WIDTH];
      end
      OP_MUL: c_res = product;
      OP_DIV: begin
        c_res = RW'({WIDTH{1'b1}});
        c_rem = s1_a;
        c_dbz = 1'b1;
      end
      OP_SLL: c_res = RW'(s1_a << s1_shamt);
      OP_SRL: c_res = RW'(s1_a >> s1_shamt);
      OP_SRA: c_res = RW'(sra_v);
      OP_ROR: c_res = RW'(ror_v);
      OP_AND: c_res = RW'(s1_a & s1_b);
      OP_OR:  c_res = RW'(s1_a | s1_b);
      OP_XOR: c_res = RW'(s1_a ^ s1_b);
      OP_CMP: c_res = RW'({s1_a == s1_b, s1_a < s1_b});
      default: c_ill = 1'b1;
    endcase
  end

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .take      (s2_load),
    .dividend  (s1_a),
    .divisor   (s1_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.result      <= '0;
      bus.remainder   <= '0;
      bus.carry_out   <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.illegal_op  <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= div_done || s1_fire;
      if (div_done) begin
        bus.result      <= RW'(div_q);
        bus.remainder   <= div_r;
        bus.carry_out   <= 1'b0;
        bus.div_by_zero <= 1'b0;
        bus.illegal_op  <= 1'b0;
      end else if (s1_fire) begin
        bus.result      <= c_res;
        bus.remainder   <= c_rem;
        bus.carry_out   <= c_carry;
        bus.div_by_zero <= c_dbz;
        bus.illegal_op  <= c_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_gen.sv
// Bench for alu_pipe_gen at WIDTH=16 and WIDTH=32: directed vectors, an
// arithmetic reference model feeding per-instance expected queues.
module tb_alu_pipe_gen;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_gen_if #(.WIDTH(16)) if16 ();
  alu_pipe_gen_if #(.WIDTH(32)) if32 ();

  alu_pipe_gen #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  alu_pipe_gen #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  int checks = 0;
  int errors = 0;

  logic [50:0] exp16_q[$];
  logic [98:0] exp32_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values, masked to width w.
  function automatic void model(input int w, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic cin,
                                output logic [63:0] res, output logic [31:0] rem,
                                output logic c, output logic dbz, output logic ill);
    logic [63:0] mask, s, aa, bb, sa;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'd0, a};
    bb = {32'd0, b};
    res = '0; rem = '0; c = 1'b0; dbz = 1'b0; ill = 1'b0;
    case (op)
      4'd0:  begin s = aa + bb + 64'(cin); res = s & mask; c = s[w]; end
      4'd1:  begin s = aa + (~bb & mask) + 64'(cin); res = s & mask; c = s[w]; end
      4'd2:  res = aa * bb;
      4'd3:  if (bb == 0) begin res = mask; rem = a; dbz = 1'b1; end
             else begin res = aa / bb; rem = 32'(aa % bb); end
      4'd4:  res = (aa << sh) & mask;
      4'd5:  res = aa >> sh;
      4'd6:  begin sa = aa[w-1] ? (aa | ~mask) : aa; res = 64'($signed(sa) >>> sh) & mask; end
      4'd7:  res = ((aa >> sh) | (aa << (w - int'(sh)))) & mask;
      4'd8:  begin s = aa + 64'd1; res = s & mask; c = s[w]; end
      4'd9:  begin res = (aa - 64'd1) & mask; c = (aa != 0); end
      4'd10: res = aa & bb;
      4'd11: res = aa | bb;
      4'd12: res = aa ^ bb;
      4'd13: res = {62'd0, aa == bb, aa < bb};
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, input logic cin);
    logic [63:0] r; logic [31:0] rm; logic c, d, il;
    bit ok = 0;
    int waited = 0;
    if16.op = op; if16.a = a; if16.b = b; if16.shamt = sh; if16.cin = cin;
    if16.in_valid = 1'b1;
    while (!ok && waited < 60) begin
      #1;
      ok = if16.in_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if16.in_valid = 1'b0;
    if (ok) begin
      model(16, op, {16'd0, a}, {16'd0, b}, {1'b0, sh}, cin, r, rm, c, d, il);
      exp16_q.push_back({r[31:0], rm[15:0], c, d, il});
    end else begin
      chk("send16_timeout", if16.in_ready, 1'b1);
    end
  endtask

  task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic cin);
    logic [63:0] r; logic [31:0] rm; logic c, d, il;
    bit ok = 0;
    int waited = 0;
    if32.op = op; if32.a = a; if32.b = b; if32.shamt = sh; if32.cin = cin;
    if32.in_valid = 1'b1;
    while (!ok && waited < 60) begin
      #1;
      ok = if32.in_ready;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if32.in_valid = 1'b0;
    if (ok) begin
      model(32, op, a, b, sh, cin, r, rm, c, d, il);
      exp32_q.push_back({r, rm, c, d, il});
    end else begin
      chk("send32_timeout", if32.in_ready, 1'b1);
    end
  endtask

  // Counts negedges from now until an output transfer is offered.
  task automatic wait16(output int edges);
    edges = 0;
    while (!(if16.out_valid && if16.out_ready) && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (!(if16.out_valid && if16.out_ready)) chk("wait16_timeout", if16.out_valid, 1'b1);
  endtask

  task automatic wait32(output int edges);
    edges = 0;
    while (!(if32.out_valid && if32.out_ready) && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (!(if32.out_valid && if32.out_ready)) chk("wait32_timeout", if32.out_valid, 1'b1);
  endtask

  // Scoreboard: compare every offered transfer, and check held outputs under stall.
  logic [50:0] act16, held16;
  logic [98:0] act32, held32;
  bit stall16 = 0, stall32 = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      stall16 = 0;
      stall32 = 0;
    end else begin
      act16 = {if16.result, if16.remainder, if16.carry_out, if16.div_by_zero, if16.illegal_op};
      if (stall16) chk("hold16", {if16.out_valid, act16}, {1'b1, held16});
      if (if16.out_valid && if16.out_ready) begin
        if (exp16_q.size() == 0) chk("sb16_unexpected", exp16_q.size(), 1);
        else chk("sb16", act16, exp16_q.pop_front());
      end
      stall16 = if16.out_valid && !if16.out_ready;
      held16  = act16;

      act32 = {if32.result, if32.remainder, if32.carry_out, if32.div_by_zero, if32.illegal_op};
      if (stall32) chk("hold32", {if32.out_valid, act32}, {1'b1, held32});
      if (if32.out_valid && if32.out_ready) begin
        if (exp32_q.size() == 0) chk("sb32_unexpected", exp32_q.size(), 1);
        else chk("sb32", act32, exp32_q.pop_front());
      end
      stall32 = if32.out_valid && !if32.out_ready;
      held32  = act32;
    end
  end

  localparam int NT = 14;
  int t_op[NT] = '{4, 5, 6, 7, 8, 9, 9, 10, 11, 12, 13, 13, 14, 1};
  int t_a [NT] = '{'h00F1, 'h8000, 'h8000, 1, 'hFFFF, 0, 5, 'hF0F0, 'hF0F0, 'hF0F0, 3, 7, 9, 0};
  int t_b [NT] = '{0, 0, 0, 0, 0, 0, 0, 'h0FF0, 'h0FF0, 'h0FF0, 7, 7, 9, 1};
  int t_sh[NT] = '{4, 15, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int t_ci[NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int e;
    bit bad;
    if16.in_valid = 0; if16.out_ready = 1; if16.a = '0; if16.b = '0;
    if16.shamt = '0; if16.op = '0; if16.cin = 0;
    if32.in_valid = 0; if32.out_ready = 1; if32.a = '0; if32.b = '0;
    if32.shamt = '0; if32.op = '0; if32.cin = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready16", if16.in_ready, 1'b1);
    chk("rst_in_ready32", if32.in_ready, 1'b1);
    chk("rst_out_valid16", if16.out_valid, 1'b0);
    chk("rst_outputs16", {if16.result, if16.remainder, if16.carry_out, if16.div_by_zero, if16.illegal_op}, '0);
    rst = 1'b0;
    @(negedge clk);

    // ADD wrap: result registered on the edge after the accept edge.
    send16(OP_ADD, 16'hFFFF, 16'd1, 4'd0, 1'b0);
    wait16(e);
    chk("add_latency", e, 1);
    chk("add_result", if16.result, 32'd0);
    chk("add_carry", if16.carry_out, 1'b1);
    @(negedge clk);

    // SUB then MUL back to back.
    send16(OP_SUB, 16'd5000, 16'd1234, 4'd0, 1'b1);
    send16(OP_MUL, 16'd255, 16'd255, 4'd0, 1'b0);
    wait16(e);
    chk("sub_result", if16.result, 32'd3766);
    chk("sub_carry", if16.carry_out, 1'b1);
    @(negedge clk);
    chk("mul_b2b_valid", if16.out_valid, 1'b1);
    chk("mul_result", if16.result, 32'd65025);
    @(negedge clk);

    // DIV 20/6: intake stalled for the whole division.
    send16(OP_DIV, 16'd20, 16'd6, 4'd0, 1'b0);
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      if (if16.in_ready || if16.out_valid) bad = 1;
      @(negedge clk);
    end
    chk("div_busy_window", bad, 1'b0);
    chk("div_valid", if16.out_valid, 1'b1);
    chk("div_quotient", if16.result, 32'd3);
    chk("div_remainder", if16.remainder, 16'd2);
    @(negedge clk);

    // DIV by zero completes like a single-cycle op.
    send16(OP_DIV, 16'd100, 16'd0, 4'd0, 1'b0);
    wait16(e);
    chk("dbz_latency", e, 1);
    chk("dbz_result", if16.result, 32'h0000FFFF);
    chk("dbz_remainder", if16.remainder, 16'd100);
    chk("dbz_flag", if16.div_by_zero, 1'b1);
    @(negedge clk);

    // Shifts, rotate, inc/dec edges, logic, compare, illegal, borrow.
    for (int i = 0; i < NT; i++)
      send16(4'(t_op[i]), 16'(t_a[i]), 16'(t_b[i]), 4'(t_sh[i]), 1'(t_ci[i]));
    repeat (4) @(negedge clk);

    // Backpressure: three ADDs offered while out_ready is low for 5 cycles.
    fork
      begin
        if16.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        if16.out_ready = 1'b1;
      end
      begin
        send16(OP_ADD, 16'd1, 16'd2, 4'd0, 1'b0);
        send16(OP_ADD, 16'd3, 16'd4, 4'd0, 1'b0);
        chk("bp_in_ready_low", if16.in_ready, 1'b0);
        send16(OP_ADD, 16'd5, 16'd6, 4'd0, 1'b0);
      end
    join
    repeat (8) @(negedge clk);
    chk("bp_drained", exp16_q.size(), 0);

    // Reset in the middle of a division.
    send16(OP_DIV, 16'd60000, 16'd7, 4'd0, 1'b0);
    repeat (6) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", if16.out_valid, 1'b0);
    chk("midrst_outputs", {if16.result, if16.remainder, if16.carry_out, if16.div_by_zero, if16.illegal_op}, '0);
    chk("midrst_in_ready", if16.in_ready, 1'b1);
    exp16_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send16(OP_INC, 16'd10, 16'd0, 4'd0, 1'b0);
    wait16(e);
    chk("inc_after_rst_latency", e, 1);
    chk("inc_after_rst", if16.result, 32'd11);
    @(negedge clk);

    // WIDTH=32 instance.
    send32(OP_MUL, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b0);
    wait32(e);
    chk("mul32_result", if32.result, 64'h1_FFFFFFFE);
    @(negedge clk);
    send32(OP_ROR, 32'h80000001, 32'd0, 5'd4, 1'b0);
    wait32(e);
    chk("ror32_result", if32.result, 64'h18000000);
    @(negedge clk);
    send32(4'd15, 32'h12345678, 32'h9, 5'd0, 1'b0);
    wait32(e);
    chk("ill32_flag", if32.illegal_op, 1'b1);
    chk("ill32_result", if32.result, 64'd0);
    @(negedge clk);
    send32(OP_DIV, 32'd1000000007, 32'd97, 5'd0, 1'b0);
    wait32(e);
    chk("div32_latency", e, 34);
    @(negedge clk);
    send32(OP_ADD, 32'hFFFFFFF0, 32'h20, 5'd0, 1'b1);
    send32(OP_SRA, 32'h80000000, 32'd0, 5'd31, 1'b0);
    repeat (5) @(negedge clk);

    chk("sb16_empty_end", exp16_q.size(), 0);
    chk("sb32_empty_end", exp32_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
